// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter, LSB first, one bit per
// clock, with a word-timing pulse (ser_xtb) on beat 0 of every word.
// A hold register allows the next word to be queued while the current one
// shifts, so words can run back-to-back with no idle beat.
// Optional build macro SERIAL_TX_GAP_EN inserts GAP_BEATS idle beats
// between words (GAP state and gap counter exist only when it is defined).
module serial_word_tx #(
    parameter int WORD_BITS = 32,
    parameter int GAP_BEATS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WORD_BITS-1:0] load_data,
    output logic                 ser_data,
    output logic                 ser_xtb,
    output logic                 ser_active,
    output logic                 word_done
);
    localparam int BW = $clog2(WORD_BITS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORD_BITS - 1);

`ifdef SERIAL_TX_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    localparam logic [3:0] GAP_LAST = 4'(GAP_BEATS - 1);
    logic [3:0]           gap_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t               state;
    logic [WORD_BITS-1:0] shreg;
    logic [WORD_BITS-1:0] hold;
    logic                 hold_full;
    logic [BW-1:0]        beat;
    logic                 accept;

    // A word can only be taken when the hold slot is free; in IDLE it always is.
    assign load_ready = ~hold_full;
    assign accept     = load_valid & load_ready;

    // Outputs are pure decodes of registered state (no path from inputs).
    assign ser_active = (state == S_SHIFT);
    assign ser_data   = ser_active & shreg[0];
    assign ser_xtb    = ser_active & (beat == '0);
    assign word_done  = ser_active & (beat == LAST_BEAT);

    // Transmit FSM: shift register, hold slot, beat/gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            beat      <= '0;
`ifdef SERIAL_TX_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Idle words bypass the hold slot and start immediately.
                    if (accept) begin
                        shreg <= load_data;
                        beat  <= '0;
                        state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (beat == LAST_BEAT) begin
`ifdef SERIAL_TX_GAP_EN
                        // Every word is followed by the idle gap; a word
                        // offered now waits in hold until the gap ends.
                        state   <= S_GAP;
                        gap_cnt <= '0;
                        if (accept) begin
                            hold      <= load_data;
                            hold_full <= 1'b1;
                        end
`else
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            beat      <= '0;
                        end else if (accept) begin
                            // Same-edge handoff: no bubble between words.
                            shreg <= load_data;
                            beat  <= '0;
                        end else begin
                            shreg <= '0;
                            beat  <= '0;
                            state <= S_IDLE;
                        end
`endif
                    end else begin
                        shreg <= shreg >> 1;
                        beat  <= beat + 1'b1;
                        if (accept) begin
                            hold      <= load_data;
                            hold_full <= 1'b1;
                        end
                    end
                end

`ifdef SERIAL_TX_GAP_EN
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        beat <= '0;
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            state     <= S_SHIFT;
                        end else if (accept) begin
                            shreg <= load_data;
                            state <= S_SHIFT;
                        end else begin
                            shreg <= '0;
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (accept) begin
                            hold      <= load_data;
                            hold_full <= 1'b1;
                        end
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: expected serial beats are queued when a
// word is accepted and popped/compared by a monitor on every active beat.
module tb_serial_word_tx;
    localparam int WB = 32;
`ifdef SERIAL_TX_GAP_EN
    localparam int GAPX = 2;
`else
    localparam int GAPX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [WB-1:0] load_data = '0;
    logic          ser_data, ser_xtb, ser_active, word_done;

    typedef struct packed { logic d; logic x; logic e; } beat_t;
    beat_t q[$];

    int cmps = 0;
    int errs = 0;
    int cyc  = 0;

    serial_word_tx #(.WORD_BITS(WB), .GAP_BEATS(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .ser_data(ser_data), .ser_xtb(ser_xtb),
        .ser_active(ser_active), .word_done(word_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: active beats pop the queue, idle beats must be quiet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ser_active) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 64'(ser_active), 64'd0);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    check("ser_data", 64'(ser_data), 64'(b.d));
                    check("ser_xtb", 64'(ser_xtb), 64'(b.x));
                    check("word_done", 64'(word_done), 64'(b.e));
                end
            end else begin
                check("idle_quiet", {61'd0, ser_data, ser_xtb, word_done}, 64'd0);
            end
        end
    end

    // Offer a word (call away from a clock edge); returns 1ns after the accept edge.
    task automatic send(input logic [WB-1:0] w, output int acc);
        logic r;
        int   n = 0;
        load_valid = 1'b1;
        load_data  = w;
        forever begin
            r = load_ready;
            @(posedge clk);
            if (r || n > 200) break;
            n++;
            #1;
        end
        #1;
        check("accept_timeout", 64'(n > 200), 64'd0);
        acc = cyc;
        for (int i = 0; i < WB; i++)
            q.push_back('{d: w[i], x: (i == 0), e: (i == WB - 1)});
    endtask

    // Run until everything queued has been transmitted; count idle beats in between.
    task automatic wait_drain(input int exp_idle);
        int n = 0;
        int idle = 0;
        while ((q.size() != 0 || ser_active) && n < 5000) begin
            @(negedge clk); #1;
            if (!ser_active && q.size() != 0) idle++;
            n++;
        end
        check("drain_timeout", 64'(n >= 5000), 64'd0);
        check("idle_beats", 64'(idle), 64'(exp_idle));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!word_done && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("word_done_timeout", 64'(n >= 200), 64'd0);
    endtask

    initial begin
        int a, b, c;
        // Reset state
        #2;
        check("rst_ready", 64'(load_ready), 64'd1);
        check("rst_outs", {60'd0, ser_data, ser_xtb, ser_active, word_done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // 1: single word from IDLE, one-cycle latency to bit 0
        send(32'h0000_0005, a);
        load_valid = 1'b0;
        @(negedge clk);
        check("t1_first_xtb", {62'd0, ser_xtb, ser_active}, 64'd3);
        #1;
        wait_drain(0);
        check("t1_idle", 64'(ser_active), 64'd0);

        // 2: second word queued into hold, starts right after beat 31
        @(negedge clk); #1;
        send(32'hFFFF_FFFF, a);
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(32'h8000_0001, b);
        load_valid = 1'b0;
        @(negedge clk);
        check("t2_ready_low", 64'(load_ready), 64'd0);
        #1;
        wait_done();
`ifndef SERIAL_TX_GAP_EN
        @(negedge clk); #1;
        check("t2_back_to_back", {62'd0, ser_xtb, ser_active}, 64'd3);
        check("t2_ready_high", 64'(load_ready), 64'd1);
`endif
        wait_drain(GAPX);

        // 3: backpressure with load_valid held high over three words
        @(negedge clk); #1;
        send(32'h1234_5678, a);
        send(32'hCAFE_F00D, b);
        send(32'h0BAD_BEEF, c);
        load_valid = 1'b0;
        check("t3_first_to_second", 64'(b - a), 64'd1);
        check("t3_third_accept", 64'(c - a), 64'(WB + 1 + GAPX));
        wait_drain(2 * GAPX);

        // 4: same-edge handoff while hold is empty
        @(negedge clk); #1;
        send(32'h0F0F_3C3C, a);
        load_valid = 1'b0;
        wait_done();
        send(32'h0000_000A, b);
        load_valid = 1'b0;
`ifndef SERIAL_TX_GAP_EN
        @(negedge clk); #1;
        check("t4_handoff", {62'd0, ser_xtb, ser_active}, 64'd3);
`endif
        wait_drain(GAPX);

        // 5: reset at beat 12 with hold full
        @(negedge clk); #1;
        send(32'hA5A5_A5A5, a);
        send(32'h5A5A_5A5A, b);
        load_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        check("t5_pre_active", 64'(ser_active), 64'd1);
        rst_n = 1'b0;
        #1;
        q.delete();
        check("t5_outs_cleared", {60'd0, ser_data, ser_xtb, ser_active, word_done}, 64'd0);
        check("t5_ready", 64'(load_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("t5_stays_idle", 64'(ser_active), 64'd0);
        check("t5_ready_after", 64'(load_ready), 64'd1);

        // Another word after reset still works normally
        send(32'h0000_0003, a);
        load_valid = 1'b0;
        wait_drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial word transmitter for the serial arithmetic datapath. It accepts parallel store or accumulator words through a valid/ready handshake and shifts them out least-significant bit first, one bit per clock. Alongside the data it drives the word-timing pulse (XTB) that serial consumers such as the accumulator subtract unit use to clear their borrow/carry at each word boundary. It is the source end of the serial operand interface and supports back-to-back words with no idle beat.

## Interface
Parameters:
- `WORD_BITS`, 32: serial word length in beats; legal range 2..64.
- `GAP_BEATS`, 2: idle beats inserted between words; used only when `SERIAL_TX_GAP_EN` is defined; legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `load_valid`  in  1  parallel word offered.
- `load_ready`  out  1  transmitter can accept a word; equals NOT hold-register-full.
- `load_data`  in  WORD_BITS  parallel word; bit 0 is transmitted first.
- `ser_data`  out  1  serial data bit; 0 whenever not in SHIFT.
- `ser_xtb`  out  1  high during beat 0 of every transmitted word only.
- `ser_active`  out  1  high during every SHIFT beat.
- `word_done`  out  1  high during the last beat (beat WORD_BITS-1) of each word.

## Operation
- Storage: shift register `shreg`, hold register `hold` plus `hold_full` flag, beat counter `beat` of width clog2(WORD_BITS), gap counter.
- States: IDLE, SHIFT, GAP (GAP exists only with the macro).
- Accept: `load_valid && load_ready` at a rising edge.
  - IDLE: the accepted word loads `shreg` directly; `beat` is set to 0; next state is SHIFT. `hold` is not used.
  - SHIFT or GAP: the accepted word loads `hold` and sets `hold_full`.
- SHIFT: `ser_data` = `shreg[0]`. Each edge shifts `shreg` right by one and increments `beat`.
- End of word, edge where `beat == WORD_BITS-1`:
  - Gap disabled, `hold_full`: `shreg` <= `hold`, `hold_full` cleared, `beat` <= 0, stay in SHIFT.
  - Gap disabled, hold empty and accept on the same edge: `load_data` goes straight into `shreg`, stay in SHIFT. There is no bubble.
  - Gap disabled, nothing pending: go to IDLE.
  - Gap enabled: go to GAP.
- Outputs are combinational decodes of registered state only. There is no input-to-output combinational path.
  - `ser_xtb` = SHIFT && `beat == 0`.
  - `word_done` = SHIFT && `beat == WORD_BITS-1`.
  - `ser_active` = SHIFT.
- Reset mid-word aborts the word immediately and discards `hold`; no partial word is resumed.
- Reset values:
  - State = IDLE.
  - `ser_data`, `ser_xtb`, `ser_active`, `word_done` = 0.
  - `load_ready` = 1.
  - `shreg`, `hold`, `beat` = 0.

## Timing
- Latency: a word accepted at edge N in IDLE puts bit 0 (with `ser_xtb` = 1) on the outputs in the cycle after edge N. Bit k appears after edge N+k.
- Sustained throughput without the gap: one word per WORD_BITS cycles, with no dead beat between words.
- `load_ready` drops in the cycle after a word is accepted into `hold`. It rises in the cycle after the end-of-word edge that drains `hold`.
- At most two words are in flight: one in `shreg` and one in `hold`.
- On a simultaneous end-of-word edge and accept while `hold_full`, no accept occurs because `load_ready` = 0. That word is accepted on a later edge.

## Configuration
- `SERIAL_TX_GAP_EN` defined:
  - After every word, the block spends exactly GAP_BEATS cycles in GAP with `ser_data` = 0, `ser_xtb` = 0 and `ser_active` = 0.
  - It then loads `hold` (or a same-edge accept) into SHIFT, or goes to IDLE if nothing is pending.
  - Accepts during GAP go to `hold`.
- `SERIAL_TX_GAP_EN` undefined: the GAP state and gap counter are not built, and words run back-to-back.

## Test plan
1. Reset, then load 0x00000005 in IDLE. Expect `ser_data` 1,0,1 followed by 29 zeros; `ser_xtb` high on the first beat only; `word_done` high on beat 31; then IDLE with `ser_active` = 0.
2. Load 0xFFFFFFFF, then 0x80000001 three cycles later. Expect `load_ready` = 0 from the cycle after the second accept. Expect the second word to start on the beat immediately after beat 31 of the first, with `ser_xtb` high again and no idle beat.
3. Backpressure: hold `load_valid` high with three distinct words. Expect the third word accepted only on the edge after the first word's end-of-word edge. Expect the serial stream to be the three words in order, with no gaps.
4. Same-edge handoff: with `hold` empty, assert `load_valid` with 0x0000000A exactly during beat 31. Expect bit 0 of 0x0000000A on the next beat, with `ser_xtb` = 1.
5. Assert `rst_n` low at beat 12 of a word with `hold` full. Expect all serial outputs 0 asynchronously and `load_ready` = 1; after release, expect no output until a new load.
6. With `SERIAL_TX_GAP_EN` and GAP_BEATS = 2, send two queued words. Expect exactly 2 beats with `ser_active` = 0 and `ser_data` = 0 between `word_done` and the next `ser_xtb`.
